// File: rtl/axi_burst_master_if.sv
// rtl/axi_burst_master_if.sv - AXI4 AW/W/B/AR/R channel bundle for the burst master
interface axi_burst_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [3:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wlast, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arlen, arsize, arburst, arvalid, input arready,
      input rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awaddr, awlen, awsize, awburst, awvalid, output awready,
      input wdata, wlast, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arlen, arsize, arburst, arvalid, output arready,
      output rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-command AXI4 INCR burst initiator (write or read, 1..16 beats)
module axi_burst_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [3:0]            cmd_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  done,
   output logic [1:0]            done_resp,
   output logic                  done_err,
   axi_burst_master_if.master    axi
);
   localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [1:0]            resp_q, resp_d;
   logic                  err_q, err_d;

   // State and captured-command registers; reset aborts any burst in flight
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         resp_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   // Next state, beat counting and worst-response / rlast-mismatch accumulation
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               cnt_d   = '0;
               resp_d  = '0;
               err_d   = 1'b0;
               state_d = cmd_write ? WR_ADDR : RD_ADDR;
            end
         end
         WR_ADDR: begin
            if (axi.awready) state_d = WR_DATA;
         end
         WR_DATA: begin
            if (wr_valid && axi.wready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == len_q) state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi.bvalid) begin
               resp_d  = axi.bresp;
               state_d = DONE;
            end
         end
         RD_ADDR: begin
            if (axi.arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (axi.rvalid && rd_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (axi.rresp > resp_q) resp_d = axi.rresp;
               // rlast must coincide exactly with the final expected beat
               if (axi.rlast != (cnt_q == len_q)) err_d = 1'b1;
               if (axi.rlast || (cnt_q == len_q)) state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Channel outputs: valids decoded from registered state, data paths pass through
   always_comb begin
      cmd_ready   = (state_q == IDLE);
      axi.awaddr  = addr_q;
      axi.awlen   = len_q;
      axi.awsize  = AX_SIZE;
      axi.awburst = BURST_INCR;
      axi.awvalid = (state_q == WR_ADDR);
      axi.wdata   = wr_data;
      axi.wvalid  = (state_q == WR_DATA) && wr_valid;
      axi.wlast   = (state_q == WR_DATA) && (cnt_q == len_q);
      wr_ready    = (state_q == WR_DATA) && axi.wready;
      axi.bready  = (state_q == WR_RESP);
      axi.araddr  = addr_q;
      axi.arlen   = len_q;
      axi.arsize  = AX_SIZE;
      axi.arburst = BURST_INCR;
      axi.arvalid = (state_q == RD_ADDR);
      axi.rready  = (state_q == RD_DATA) && rd_ready;
      rd_valid    = (state_q == RD_DATA) && axi.rvalid;
      rd_data     = axi.rdata;
      done        = (state_q == DONE);
      done_resp   = resp_q;
      done_err    = err_q;
   end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - scoreboard bench for axi_burst_master with random slave/upstream timing
module tb_axi_burst_master;
   localparam int AW = 32;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [3:0]    cmd_len;
   logic [DW-1:0] wr_data, rd_data;
   logic          wr_valid, wr_ready, rd_valid, rd_ready;
   logic          done, done_err;
   logic [1:0]    done_resp;

   axi_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp), .done_err(done_err),
      .axi(axi)
   );

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] addr; logic [3:0] len; } ax_t;
   typedef struct { logic [DW-1:0] data; logic last; } wb_t;
   typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } rb_t;
   typedef struct { logic [1:0] resp; logic err; } dn_t;

   ax_t           aw_exp[$], ar_exp[$];
   wb_t           w_exp[$];
   logic [DW-1:0] rd_exp[$];
   dn_t           dn_exp[$];
   logic [DW-1:0] wr_src[$];
   rb_t           r_src[$];

   int tests = 0;
   int fails = 0;
   int w_seen = 0;

   int p_wv = 100, p_w = 100, p_rv = 100, p_rr = 100, p_b = 100;
   int aw_delay = 0, ar_delay = 0;
   bit rr_toggle = 1'b0;
   logic [1:0] b_plan = 2'b00;

   logic [DW-1:0] dat[16];
   logic [1:0]    rsp[16];
   logic [1:0]    bresp_v;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event occurred, expected it not to", name);
   endtask

   function automatic bit roll(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   // Slave and upstream driver: acts on handshakes seen last cycle, drives at negedge, samples at +1
   bit f_w, f_wl, f_b, f_aw, f_ar, f_r, b_pend, r_act;
   int aw_cnt = 0, ar_cnt = 0;
   always @(negedge clk) begin
      if (f_w && wr_src.size() > 0) void'(wr_src.pop_front());
      if (f_wl) b_pend = 1'b1;
      if (f_b) b_pend = 1'b0;
      if (f_ar) r_act = 1'b1;
      if (f_r && r_src.size() > 0) void'(r_src.pop_front());
      if (r_src.size() == 0) r_act = 1'b0;
      if (f_aw) aw_cnt = 0;
      if (f_ar) ar_cnt = 0;
      if (!(wr_valid && !f_w)) wr_valid = (wr_src.size() > 0) && roll(p_wv);
      wr_data = (wr_src.size() > 0) ? wr_src[0] : '0;
      axi.wready  = roll(p_w);
      axi.awready = (aw_cnt >= aw_delay);
      axi.arready = (ar_cnt >= ar_delay);
      if (!(axi.bvalid && !f_b)) axi.bvalid = b_pend && roll(p_b);
      axi.bresp = b_plan;
      if (!(axi.rvalid && !f_r)) axi.rvalid = r_act && roll(p_rv);
      if (r_src.size() > 0) begin
         axi.rdata = r_src[0].data;
         axi.rresp = r_src[0].resp;
         axi.rlast = r_src[0].last;
      end else begin
         axi.rdata = '0;
         axi.rresp = 2'b00;
         axi.rlast = 1'b0;
      end
      rd_ready = rr_toggle ? !rd_ready : roll(p_rr);
      #1;
      if (!rstn) begin
         wr_src.delete();
         r_src.delete();
         {f_w, f_wl, f_b, f_aw, f_ar, f_r, b_pend, r_act} = '0;
         aw_cnt = 0;
         ar_cnt = 0;
         wr_valid = 1'b0;
         axi.bvalid = 1'b0;
         axi.rvalid = 1'b0;
      end else begin
         f_w  = wr_valid && wr_ready;
         f_wl = f_w && axi.wlast;
         f_b  = axi.bvalid && axi.bready;
         f_aw = axi.awvalid && axi.awready;
         f_ar = axi.arvalid && axi.arready;
         f_r  = axi.rvalid && axi.rready;
         if (axi.awvalid) aw_cnt++;
         if (axi.arvalid) ar_cnt++;
      end
   end

   // Monitor: pops expected items whenever the DUT presents a transfer or completion
   always @(negedge clk) begin
      #2;
      if (rstn) begin
         chk("aw_ar_exclusive", {63'd0, axi.awvalid & axi.arvalid}, 64'd0);
         if (axi.awvalid) begin
            if (aw_exp.size() == 0) note_fail("aw_unexpected");
            else begin
               chk("awaddr", axi.awaddr, aw_exp[0].addr);
               chk("awlen", axi.awlen, aw_exp[0].len);
               chk("awburst", axi.awburst, 2'b01);
               chk("awsize", axi.awsize, 3'd0);
               if (axi.awready) void'(aw_exp.pop_front());
            end
         end
         if (axi.arvalid) begin
            if (ar_exp.size() == 0) note_fail("ar_unexpected");
            else begin
               chk("araddr", axi.araddr, ar_exp[0].addr);
               chk("arlen", axi.arlen, ar_exp[0].len);
               chk("arburst", axi.arburst, 2'b01);
               chk("arsize", axi.arsize, 3'd0);
               if (axi.arready) void'(ar_exp.pop_front());
            end
         end
         if (axi.wvalid && axi.wready) begin
            w_seen++;
            if (w_exp.size() == 0) note_fail("w_unexpected");
            else begin
               chk("wdata", axi.wdata, w_exp[0].data);
               chk("wlast", axi.wlast, w_exp[0].last);
               void'(w_exp.pop_front());
            end
         end
         if (rd_valid && rd_ready) begin
            if (rd_exp.size() == 0) note_fail("rd_unexpected");
            else chk("rd_data", rd_data, rd_exp.pop_front());
         end
         if (done) begin
            if (dn_exp.size() == 0) note_fail("done_unexpected");
            else begin
               chk("done_resp", done_resp, dn_exp[0].resp);
               chk("done_err", done_err, dn_exp[0].err);
               void'(dn_exp.pop_front());
            end
         end
      end
   end

   task automatic clear_exp();
      aw_exp.delete(); ar_exp.delete(); w_exp.delete(); rd_exp.delete(); dn_exp.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      clear_exp();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // mode for reads: 0 = rlast on final beat, 1 = early rlast on beat k, 2 = rlast never asserted
   task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [3:0] len,
                          input int mode, input int k, input bit wait_done);
      bit ok;
      int n;
      dn_t d;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) note_fail("cmd_ready_timeout");
      if (wr) begin
         aw_exp.push_back('{addr, len});
         for (int i = 0; i <= int'(len); i++) begin
            w_exp.push_back('{dat[i], i == int'(len)});
            wr_src.push_back(dat[i]);
         end
         b_plan = bresp_v;
         d = '{bresp_v, 1'b0};
      end else begin
         n = (mode == 1) ? k + 1 : int'(len) + 1;
         d = '{2'b00, mode != 0};
         ar_exp.push_back('{addr, len});
         for (int i = 0; i < n; i++) begin
            r_src.push_back('{dat[i], rsp[i],
                             (mode == 0) ? (i == int'(len)) : ((mode == 1) ? (i == k) : 1'b0)});
            rd_exp.push_back(dat[i]);
            if (rsp[i] > d.resp) d.resp = rsp[i];
         end
      end
      dn_exp.push_back(d);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = $urandom_range(1);
      cmd_addr  = $urandom;
      cmd_len   = 4'($urandom);
      if (wait_done) begin
         ok = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            if (dn_exp.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
            #3;
         end
         if (!ok) begin
            note_fail("done_timeout");
            do_reset();
         end else begin
            @(negedge clk);
            #1;
            chk("cmd_ready_after_done", cmd_ready, 1'b1);
            chk("done_resp_held", done_resp, d.resp);
            chk("done_err_held", done_err, d.err);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int base, len, mode, k;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_awvalid", axi.awvalid, 1'b0);
      chk("rst_arvalid", axi.arvalid, 1'b0);
      chk("rst_wvalid", axi.wvalid, 1'b0);
      chk("rst_bready", axi.bready, 1'b0);
      chk("rst_rready", axi.rready, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_done_resp", done_resp, 2'b00);
      chk("rst_done_err", done_err, 1'b0);
      chk("rst_awaddr", axi.awaddr, 32'd0);
      chk("rst_awlen", axi.awlen, 4'd0);
      chk("rst_araddr", axi.araddr, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // always-ready write of A1..A4
      for (int i = 0; i < 4; i++) dat[i] = 8'hA1 + 8'(i);
      bresp_v = 2'b00;
      run_cmd(1'b1, 32'h10, 4'd3, 0, 0, 1'b1);

      // two-beat read
      dat[0] = 8'h55; dat[1] = 8'h66; rsp[0] = 2'b00; rsp[1] = 2'b00;
      run_cmd(1'b0, 32'h20, 4'd1, 0, 0, 1'b1);

      // SLVERR on one beat, rd_ready toggling
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      rsp[0] = 2'b00; rsp[1] = 2'b10; rsp[2] = 2'b00; rsp[3] = 2'b00;
      rr_toggle = 1'b1;
      run_cmd(1'b0, 32'h30, 4'd3, 0, 0, 1'b1);
      rr_toggle = 1'b0;

      // delayed awready, gapped write data, EXOKAY
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      bresp_v = 2'b01; aw_delay = 5; p_wv = 50;
      run_cmd(1'b1, 32'h40, 4'd3, 0, 0, 1'b1);
      aw_delay = 0; p_wv = 100;

      // early rlast on second beat, then missing rlast
      for (int i = 0; i < 4; i++) begin dat[i] = 8'($urandom); rsp[i] = 2'b00; end
      run_cmd(1'b0, 32'h50, 4'd3, 1, 1, 1'b1);
      run_cmd(1'b0, 32'h60, 4'd2, 2, 0, 1'b1);

      // 16-beat write and read at the length limit
      for (int i = 0; i < 16; i++) begin dat[i] = 8'($urandom); rsp[i] = 2'($urandom_range(3)); end
      bresp_v = 2'b11;
      run_cmd(1'b1, 32'hFF8, 4'd15, 0, 0, 1'b1);
      run_cmd(1'b0, 32'hFF0, 4'd15, 0, 0, 1'b1);

      // reset in the middle of a write burst
      for (int i = 0; i < 6; i++) dat[i] = 8'($urandom);
      bresp_v = 2'b00;
      base = w_seen;
      run_cmd(1'b1, 32'h70, 4'd5, 0, 0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #3;
         if (w_seen >= base + 2) begin ok = 1'b1; break; end
      end
      if (!ok) note_fail("mid_burst_timeout");
      @(negedge clk);
      rstn = 1'b0;
      clear_exp();
      @(negedge clk);
      #1;
      chk("abort_wvalid", axi.wvalid, 1'b0);
      chk("abort_awvalid", axi.awvalid, 1'b0);
      chk("abort_cmd_ready", cmd_ready, 1'b1);
      chk("abort_done", done, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) dat[i] = 8'($urandom);
      bresp_v = 2'b10;
      run_cmd(1'b1, 32'h80, 4'd2, 0, 0, 1'b1);

      // randomized commands and handshake timing
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) begin dat[i] = 8'($urandom); rsp[i] = 2'($urandom_range(3)); end
         bresp_v = 2'($urandom_range(3));
         p_wv = $urandom_range(30, 100); p_w = $urandom_range(30, 100);
         p_rv = $urandom_range(30, 100); p_rr = $urandom_range(30, 100);
         p_b = $urandom_range(30, 100);
         aw_delay = $urandom_range(3); ar_delay = $urandom_range(3);
         rr_toggle = ($urandom_range(3) == 0);
         len = $urandom_range(15);
         mode = $urandom_range(5);
         mode = (mode < 4) ? 0 : ((mode == 4 && len > 0) ? 1 : 2);
         k = (len > 0) ? $urandom_range(len - 1) : 0;
         run_cmd($urandom_range(1) == 1, $urandom, 4'(len), mode, k, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
